axi_burst_traffic_gen: RTL and testbench

- AXI4-style test traffic generator for the DDR2 controller's AXI slave port.
- After controller init completes, a trigger pulse starts a fixed program:
  - DATA_LEVEL incrementing-data write bursts, then
  - DATA_LEVEL read bursts over the same addresses.
- Sits beside the DDR2 controller in simulation and bring-up benches.

---
 rtl/axi_burst_traffic_gen_pkg.sv | 29 ++
 rtl/axi_traffic_rd_checker.sv | 59 +++++
 rtl/axi_burst_traffic_gen.sv | 170 +++++++++++++++++
 tb/tb_axi_burst_traffic_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_traffic_gen_pkg.sv
// Shared types and helpers for the AXI burst traffic generator.
// Optional read-data checking is enabled by defining AXI_TRAFFIC_RDCHECK_EN.
package axi_burst_traffic_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } state_e;

  localparam int DEF_ADDR_WIDTH = 25;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DATA_LEVEL = 2;
  localparam int DEF_WBURST_LEN = 8;
  localparam int DEF_RBURST_LEN = 8;

  // Encoded AXI length fields for the default burst lengths.
  localparam logic [7:0] AWLEN_C = 8'(DEF_WBURST_LEN - 1);
  localparam logic [7:0] ARLEN_C = 8'(DEF_RBURST_LEN - 1);

  // Start address of burst k in beat units; callers truncate to their width.
  function automatic logic [31:0] burst_base(input logic [31:0] k, input logic [31:0] len);
    return k * len;
  endfunction

endpackage

// File: rtl/axi_traffic_rd_checker.sv
// Read-data checker: tracks burst/beat position, compares each read beat
// against the incrementing pattern, keeps a sticky error flag and pulses
// done when the final read burst of a program completes.
module axi_traffic_rd_checker
  import axi_burst_traffic_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LEVEL = DEF_DATA_LEVEL,
  parameter int RBURST_LEN = DEF_RBURST_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_beat,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rd_err,
  output logic                  o_rd_done
);

  localparam int KW = (DATA_LEVEL > 1) ? $clog2(DATA_LEVEL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_LEVEL - 1);

  logic [KW-1:0]         r_k;
  logic [8:0]            r_beat;
  logic [DATA_WIDTH-1:0] w_exp;

  assign w_exp = DATA_WIDTH'(burst_base(32'(r_k), 32'(RBURST_LEN)) + 32'(r_beat));

  // Position tracking, sticky mismatch flag and end-of-program pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k       <= '0;
      r_beat    <= '0;
      o_rd_err  <= 1'b0;
      o_rd_done <= 1'b0;
    end else begin
      o_rd_done <= 1'b0;
      if (i_clear) begin
        r_k    <= '0;
        r_beat <= '0;
      end else if (i_beat) begin
        if (i_rdata != w_exp) o_rd_err <= 1'b1;
        if (i_last) begin
          r_beat <= '0;
          if (r_k == K_LAST) begin
            r_k       <= '0;
            o_rd_done <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_burst_traffic_gen.sv
// AXI4-style burst traffic generator: on a trigger edge (with init done),
// issues DATA_LEVEL incrementing-data write bursts, then DATA_LEVEL read
// bursts over the same addresses. Define AXI_TRAFFIC_RDCHECK_EN to add
// read-data checking with o_rd_err / o_rd_done outputs.
//
// state   | meaning
// IDLE    | waiting for a qualified trigger edge
// AW      | presenting write address for burst k
// W       | streaming write beats of burst k
// B       | accepting write response for burst k
// AR      | presenting read address for burst k
// R       | accepting read beats until rlast
module axi_burst_traffic_gen
  import axi_burst_traffic_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LEVEL = DEF_DATA_LEVEL,
  parameter int WBURST_LEN = DEF_WBURST_LEN,
  parameter int RBURST_LEN = DEF_RBURST_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_w_trig,
  input  logic                  i_init_end,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic                  o_wlast,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic                  i_rlast,
  input  logic [DATA_WIDTH-1:0] i_rdata
`ifdef AXI_TRAFFIC_RDCHECK_EN
  ,
  output logic                  o_rd_err,
  output logic                  o_rd_done
`endif
);

  localparam int KW = (DATA_LEVEL > 1) ? $clog2(DATA_LEVEL) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(DATA_LEVEL - 1);
  localparam logic [8:0]    WBEAT_LAST = 9'(WBURST_LEN - 1);

  state_e        r_state;
  state_e        w_next;
  logic [KW-1:0] r_k;
  logic [8:0]    r_beat;
  logic          r_trig_q;

  logic        w_go;
  logic        w_w_hs;
  logic        w_rlast_hs;
  logic        w_k_last;
  logic        w_wbeat_last;
  logic [31:0] w_waddr;
  logic [31:0] w_raddr;

  assign w_go         = (r_state == ST_IDLE) & i_w_trig & ~r_trig_q & i_init_end;
  assign w_w_hs       = (r_state == ST_W) & i_wready;
  assign w_rlast_hs   = (r_state == ST_R) & i_rvalid & i_rlast;
  assign w_k_last     = (r_k == K_LAST);
  assign w_wbeat_last = (r_beat == WBEAT_LAST);

  assign w_waddr  = burst_base(32'(r_k), 32'(WBURST_LEN));
  assign w_raddr  = burst_base(32'(r_k), 32'(RBURST_LEN));
  assign o_awaddr = ADDR_WIDTH'(w_waddr);
  assign o_araddr = ADDR_WIDTH'(w_raddr);
  assign o_wdata  = DATA_WIDTH'(w_waddr + 32'(r_beat));
  assign o_awlen  = 8'(WBURST_LEN - 1);
  assign o_arlen  = 8'(RBURST_LEN - 1);

  // Trigger history for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_trig_q <= 1'b0;
    else       r_trig_q <= i_w_trig;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_go)             w_next = ST_AW;
      ST_AW:   if (i_awready)        w_next = ST_W;
      ST_W:    if (i_wready && w_wbeat_last) w_next = ST_B;
      ST_B:    if (i_bvalid)         w_next = w_k_last ? ST_AR : ST_AW;
      ST_AR:   if (i_arready)        w_next = ST_R;
      ST_R:    if (w_rlast_hs)       w_next = w_k_last ? ST_IDLE : ST_AR;
      default:                       w_next = ST_IDLE;
    endcase
  end

  // Burst index k and write beat index; k wraps to 0 after the last write
  // and last read burst so both phases start at burst 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k    <= '0;
      r_beat <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_go) begin
          r_k    <= '0;
          r_beat <= '0;
        end
        ST_W: if (w_w_hs) r_beat <= w_wbeat_last ? 9'd0 : r_beat + 9'd1;
        ST_B: if (i_bvalid) r_k <= w_k_last ? '0 : r_k + 1'b1;
        ST_R: if (w_rlast_hs) r_k <= w_k_last ? '0 : r_k + 1'b1;
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_wlast   = 1'b0;
    o_bready  = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    unique case (r_state)
      ST_AW: o_awvalid = 1'b1;
      ST_W: begin
        o_wvalid = 1'b1;
        o_wlast  = w_wbeat_last;
      end
      ST_B:  o_bready  = 1'b1;
      ST_AR: o_arvalid = 1'b1;
      ST_R:  o_rready  = 1'b1;
      default: ;
    endcase
  end

`ifdef AXI_TRAFFIC_RDCHECK_EN
  axi_traffic_rd_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_LEVEL (DATA_LEVEL),
    .RBURST_LEN (RBURST_LEN)
  ) u_rd_checker (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_go),
    .i_beat    ((r_state == ST_R) & i_rvalid),
    .i_last    (i_rlast),
    .i_rdata   (i_rdata),
    .o_rd_err  (o_rd_err),
    .o_rd_done (o_rd_done)
  );
`else
  logic w_rdata_unused;
  assign w_rdata_unused = ^i_rdata;
`endif

endmodule

// File: tb/tb_axi_burst_traffic_gen.sv
module tb_axi_burst_traffic_gen;

  localparam int AWD = 25;
  localparam int DWD = 32;
  localparam int DL  = 2;
  localparam int WL  = 8;
  localparam int RL  = 8;

  logic clk = 1'b0;
  logic rst, trig, init_end;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [AWD-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [DWD-1:0] wdata, rdata;
`ifdef AXI_TRAFFIC_RDCHECK_EN
  logic rd_err, rd_done;
`endif

  always #5 clk = ~clk;

  axi_burst_traffic_gen dut (
    .i_clk(clk), .i_rst(rst), .i_w_trig(trig), .i_init_end(init_end),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awlen(awlen),
    .o_wvalid(wvalid), .i_wready(wready), .o_wlast(wlast), .o_wdata(wdata),
    .i_bvalid(bvalid), .o_bready(bready),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
    .i_rvalid(rvalid), .o_rready(rready), .i_rlast(rlast), .i_rdata(rdata)
`ifdef AXI_TRAFFIC_RDCHECK_EN
    , .o_rd_err(rd_err), .o_rd_done(rd_done)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard queues filled by the reference model when a program starts.
  int aw_q[$];
  int wd_q[$];
  bit wl_q[$];
  int ar_q[$];

  int  aw_hs_n = 0;
  int  rd_bursts_done = 0;
  int  rd_done_n = 0;
  int  rd_base = 0;
  bit  awvalid_seen = 0;
  int  aw_stall = 0;
  bit  rnd = 0;
  bit  corrupt = 0;
  int  mem[int];

  // Slave model: samples handshakes at negedge, updates drives after posedge.
  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, s_wlast, s_rlast, s_awv, b_pend, r_act;
    int s_awaddr, s_araddr, s_wdata, aw_cnt, wbeat, rbeat, raddr, a;
    int wa_q[$];
    int ra_q[$];
    awready = 0; wready = 0; bvalid = 0; arready = 0;
    rvalid = 0; rlast = 0; rdata = '0;
    b_pend = 0; r_act = 0; aw_cnt = 0; wbeat = 0; rbeat = 0; raddr = 0;
    forever begin
      @(negedge clk);
      hs_aw = awvalid & awready;  hs_w = wvalid & wready;
      hs_b  = bvalid & bready;    hs_ar = arvalid & arready;
      hs_r  = rvalid & rready;    s_wlast = wlast; s_rlast = rlast;
      s_awv = awvalid;
      s_awaddr = int'(awaddr); s_araddr = int'(araddr); s_wdata = int'(wdata);
      @(posedge clk); #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        b_pend = 0; r_act = 0; aw_cnt = 0; wbeat = 0; rbeat = 0;
        wa_q.delete(); ra_q.delete();
        continue;
      end
      if (hs_aw) begin
        wa_q.push_back(s_awaddr);
        aw_cnt = 0;
      end else if (s_awv) aw_cnt++;
      if (hs_w && wa_q.size() > 0) begin
        mem[wa_q[0] + wbeat] = s_wdata;
        if (s_wlast) begin
          void'(wa_q.pop_front());
          wbeat = 0;
          b_pend = 1;
        end else wbeat++;
      end
      if (hs_b) b_pend = 0;
      if (hs_ar) ra_q.push_back(s_araddr);
      if (hs_r) begin
        if (s_rlast) begin
          r_act = 0;
          rd_bursts_done++;
        end else rbeat++;
      end
      if (!r_act && ra_q.size() > 0) begin
        raddr = ra_q.pop_front();
        r_act = 1;
        rbeat = 0;
      end
      awready = (aw_cnt >= aw_stall) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      wready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      arready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bvalid  = b_pend && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      rvalid  = r_act && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      rlast   = r_act && (rbeat == RL - 1);
      a = raddr + rbeat;
      rdata = mem.exists(a) ? DWD'(mem[a]) : '0;
      if (corrupt && r_act && (rd_bursts_done - rd_base == 1) && rbeat == 3)
        rdata = rdata ^ 32'h1;
    end
  end

  // Monitor: pops expected values on each DUT handshake and checks holds.
  bit       p_aw_stall = 0, p_w_stall = 0, p_wlast = 0;
  int       p_awaddr = 0, p_wdata = 0;
  always @(negedge clk) begin
    if (rst) begin
      p_aw_stall = 0;
      p_w_stall  = 0;
    end else begin
      if (awvalid) awvalid_seen = 1;
      if (p_aw_stall) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, p_awaddr);
      end
      if (p_w_stall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, p_wdata);
        chk("w_hold_last", wlast, p_wlast);
      end
      if (awvalid && awready) begin
        aw_hs_n++;
        chk("aw_expected", aw_q.size() > 0, 1);
        if (aw_q.size() > 0) chk("awaddr", awaddr, aw_q.pop_front());
        chk("awlen", awlen, WL - 1);
      end
      if (wvalid && wready) begin
        chk("w_expected", wd_q.size() > 0, 1);
        if (wd_q.size() > 0) begin
          chk("wdata", wdata, wd_q.pop_front());
          chk("wlast", wlast, wl_q.pop_front());
        end
      end
      if (arvalid && arready) begin
        chk("ar_expected", ar_q.size() > 0, 1);
        if (ar_q.size() > 0) chk("araddr", araddr, ar_q.pop_front());
        chk("arlen", arlen, RL - 1);
      end
`ifdef AXI_TRAFFIC_RDCHECK_EN
      if (rd_done) rd_done_n++;
`endif
      p_aw_stall = awvalid & ~awready;
      p_awaddr   = int'(awaddr);
      p_w_stall  = wvalid & ~wready;
      p_wdata    = int'(wdata);
      p_wlast    = wlast;
    end
  end

  task automatic pulse_trig();
    @(posedge clk); #1 trig = 1;
    @(posedge clk); #1 trig = 0;
  endtask

  task automatic run(input int stall, input bit r, input bit retrig, input bit corr);
    int base_aw, base_done, cyc;
    aw_stall = stall; rnd = r; corrupt = corr;
    rd_base = rd_bursts_done; base_aw = aw_hs_n; base_done = rd_done_n;
    for (int k = 0; k < DL; k++) begin
      aw_q.push_back(k * WL);
      for (int i = 0; i < WL; i++) begin
        wd_q.push_back(k * WL + i);
        wl_q.push_back(i == WL - 1);
      end
    end
    for (int k = 0; k < DL; k++) ar_q.push_back(k * RL);
    pulse_trig();
    if (retrig) begin
      cyc = 0;
      while (!wvalid && cyc < 300) begin @(posedge clk); #1; cyc++; end
      chk("retrig_reached_w", wvalid, 1);
      pulse_trig();
    end
    cyc = 0;
    while (rd_bursts_done - rd_base < DL && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    chk("program_complete", rd_bursts_done - rd_base, DL);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("idle_awvalid", awvalid, 0);
    chk("idle_wvalid", wvalid, 0);
    chk("idle_bready", bready, 0);
    chk("idle_arvalid", arvalid, 0);
    chk("idle_rready", rready, 0);
    chk("aw_bursts", aw_hs_n - base_aw, DL);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", wd_q.size(), 0);
    chk("ar_q_empty", ar_q.size(), 0);
`ifdef AXI_TRAFFIC_RDCHECK_EN
    chk("rd_done_pulses", rd_done_n - base_done, 1);
`endif
  endtask

  initial begin : main
    rst = 1; trig = 0; init_end = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_awlen", awlen, 7);
    chk("rst_arlen", arlen, 7);
`ifdef AXI_TRAFFIC_RDCHECK_EN
    chk("rst_rd_err", rd_err, 0);
`endif
    @(posedge clk); #1 rst = 0;

    pulse_trig();
    repeat (5) @(posedge clk);
    #1 init_end = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_start_without_edge", awvalid_seen, 0);

    run(0, 0, 0, 0);
    run(5, 1, 1, 0);
    for (int n = 0; n < 3; n++) run(int'($urandom_range(0, 3)), 1, 0, 0);

`ifdef AXI_TRAFFIC_RDCHECK_EN
    chk("echo_rd_err", rd_err, 0);
    run(0, 1, 0, 1);
    chk("corrupt_rd_err", rd_err, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("corrupt_rd_err_sticky", rd_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
